// File: rtl/spi_slave_buffered.sv
`default_nettype none
// ============================================================================
// Module      : spi_fifo / spi_slave_buffered
// Description : SPI responder with TX/RX FIFOs. sclk/mosi/cs are oversampled
//               in the clk domain; cpol/cpha/lsb_first select the mode.
// Revision    : 1.0 - initial release
// ============================================================================

module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // Fullness/emptiness judged on the registered count, before this cycle's push/pop
  always_comb begin
    do_wr    = wr_en && (count_q != (AW+1)'(DEPTH));
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
endmodule

module spi_slave_buffered #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    FIFO_DEPTH  = 16,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic                          lsb_first,
  input  logic                          sclk,
  input  logic                          mosi,
  input  logic                          cs,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic                          tx_wr_en,
  input  logic [DATA_WIDTH-1:0]         tx_wr_data,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  input  logic                          rx_rd_en,
  output logic [DATA_WIDTH-1:0]         rx_rd_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          byte_done,
  output logic                          tx_underrun,
  output logic                          rx_overrun,
  input  logic                          clr_err
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic                    sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic                    byte_done_q, byte_done_d;
  logic                    underrun_q, underrun_d, overrun_q, overrun_d;

  logic sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic sample_edge, shift_edge, do_load, tx_pop, underrun_set;
  logic tx_empty, rx_full;
  logic [DATA_WIDTH-1:0] tx_head;

  // Synchronizer chains and the edge-detect register behind them
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_rise   = sclk_s && !sclk_prev_q;
    sclk_fall   = !sclk_s && sclk_prev_q;
    cs_fall     = !cs_s && cs_prev_q;
    cs_rise     = cs_s && !cs_prev_q;
    // Sampling happens on the rising edge when cpol==cpha, shifting on the other
    sample_edge = (cpol == cpha) ? sclk_rise : sclk_fall;
    shift_edge  = (cpol == cpha) ? sclk_fall : sclk_rise;
  end

  // Frame FSM: bit counting, RX shifting and TX load/shift decisions
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    byte_done_d  = 1'b0;
    do_load      = 1'b0;
    tx_pop       = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          do_load   = !cpha;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort: partial RX word and any loaded TX word are abandoned
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (sample_edge) begin
            rx_sr_d = lsb_first ? {mosi_s, rx_sr_q[DATA_WIDTH-1:1]}
                                : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == CW'(DATA_WIDTH-1)) begin
              bit_cnt_d   = '0;
              byte_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // A shift edge at bit 0 only follows a complete word (cpha=0) or
          // starts a word (cpha=1); either way it is the load point
          if (shift_edge) begin
            if (bit_cnt_q == '0) begin
              do_load = 1'b1;
            end else begin
              tx_sr_d = lsb_first ? {1'b0, tx_sr_q[DATA_WIDTH-1:1]}
                                  : {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_load) begin
      tx_pop       = !tx_empty;
      tx_sr_d      = tx_empty ? DEFAULT_TX : tx_head;
      underrun_set = tx_empty;
    end
    underrun_d = clr_err ? 1'b0 : (underrun_q || underrun_set);
    overrun_d  = clr_err ? 1'b0 : (overrun_q || (byte_done_q && rx_full));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      byte_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      byte_done_q <= byte_done_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  spi_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr_en(tx_wr_en), .wr_data(tx_wr_data), .rd_en(tx_pop),
    .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // The completed word sits in rx_sr for one cycle after the final sample
  spi_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr_en(byte_done_q), .wr_data(rx_sr_q), .rd_en(rx_rd_en),
    .rd_data(rx_rd_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign miso        = lsb_first ? tx_sr_q[0] : tx_sr_q[DATA_WIDTH-1];
  assign miso_oe     = (state_q == ACTIVE);
  assign byte_done   = byte_done_q;
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_buffered
// Description : Self-checking bench: SPI master model, vector table, and
//               scoreboard queues for MISO words and RX FIFO contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_buffered;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cpol, cpha, lsb_first, sclk, mosi, cs, miso, miso_oe;
  logic tx_wr_en, tx_full, rx_rd_en, rx_empty, byte_done, tx_underrun, rx_overrun, clr_err;
  logic [W-1:0] tx_wr_data, rx_rd_data;
  logic [4:0]   tx_count, rx_count;

  spi_slave_buffered dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso), .miso_oe(miso_oe),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .byte_done(byte_done), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun),
    .clr_err(clr_err)
  );

  int total = 0;
  int bad   = 0;
  int bd_cnt = 0;
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_miso_q[$];
  logic [W-1:0] mst_tx [0:31];
  logic [W-1:0] mst_rx [0:31];

  typedef struct {
    logic         cpol, cpha, lsb;
    logic [W-1:0] m0, m1;   // master -> slave words, expected in RX FIFO
    logic [W-1:0] s0, s1;   // slave TX words, expected on MISO
  } vec_t;
  vec_t vecs [12];

  always @(negedge clk) if (byte_done === 1'b1) bd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic a, input logic l);
    cpol = p; cpha = a; lsb_first = l; sclk = p;
    cyc(H);
  endtask

  task automatic tx_push(input logic [W-1:0] w);
    tx_wr_en = 1'b1; tx_wr_data = w;
    cyc(1);
    tx_wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
  endtask

  // Master model: clocks nbits bits of mst_tx[], capturing MISO into mst_rx[]
  task automatic xfer(input int nw, input int nbits, input bit raise_cs);
    int b;
    int nb;
    nb = (nbits < nw * W) ? nbits : nw * W;
    cs = 1'b0;
    cyc(H);
    for (int i = 0; i < nb; i++) begin
      b = lsb_first ? (i % W) : (W - 1 - (i % W));
      if (!cpha) begin
        mosi = mst_tx[i / W][b];
        cyc(H);
        mst_rx[i / W][b] = miso;
        sclk = ~cpol;
        cyc(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mst_tx[i / W][b];
        cyc(H);
        mst_rx[i / W][b] = miso;
        sclk = cpol;
        cyc(H);
      end
    end
    if (raise_cs) begin
      cyc(H);
      cs = 1'b1;
      cyc(2 * H);
    end
  endtask

  // Full frame: queue the expected RX words, run it, compare MISO words
  task automatic send(input int nw, input int nrx);
    for (int k = 0; k < nrx; k++) exp_rx_q.push_back(mst_tx[k]);
    xfer(nw, nw * W, 1'b1);
    for (int k = 0; k < nw; k++) begin
      if (exp_miso_q.size() == 0) chk("miso scoreboard underflow", 1, 0);
      else chk("miso word", {24'd0, mst_rx[k]}, {24'd0, exp_miso_q.pop_front()});
    end
  endtask

  task automatic drain_rx();
    logic [W-1:0] e;
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front();
      if (rx_empty) chk("rx fifo empty early", {31'd0, rx_empty}, 0);
      else chk("rx_rd_data", {24'd0, rx_rd_data}, {24'd0, e});
      rx_rd_en = 1'b1;
      cyc(1);
      rx_rd_en = 1'b0;
    end
    chk("rx_empty after drain", {31'd0, rx_empty}, 1);
  endtask

  initial begin
    int bd0;
    vecs[0]  = '{0, 0, 0, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[1]  = '{0, 0, 1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[2]  = '{0, 1, 0, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[3]  = '{0, 1, 1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[4]  = '{1, 0, 0, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[5]  = '{1, 0, 1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[6]  = '{1, 1, 0, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[7]  = '{1, 1, 1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[8]  = '{0, 0, 1, 8'h12, 8'hC4, 8'h3A, 8'hE1};
    vecs[9]  = '{0, 1, 1, 8'h0B, 8'h70, 8'hD2, 8'h19};
    vecs[10] = '{1, 0, 0, 8'h61, 8'h8E, 8'h07, 8'hB4};
    vecs[11] = '{1, 1, 1, 8'h35, 8'hCA, 8'h1E, 8'h8C};

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0; clr_err = 1'b0;
    cyc(5);
    rst = 1'b0;
    cyc(1);

    // Reset state
    chk("reset tx_count", {27'd0, tx_count}, 0);
    chk("reset rx_count", {27'd0, rx_count}, 0);
    chk("reset tx_full", {31'd0, tx_full}, 0);
    chk("reset rx_empty", {31'd0, rx_empty}, 1);
    chk("reset miso", {31'd0, miso}, 0);
    chk("reset miso_oe", {31'd0, miso_oe}, 0);
    chk("reset byte_done", {31'd0, byte_done}, 0);
    chk("reset flags", {30'd0, tx_underrun, rx_overrun}, 0);

    // Mode 0 MSB-first single word
    set_mode(0, 0, 0);
    tx_push(8'hA5); exp_miso_q.push_back(8'hA5);
    mst_tx[0] = 8'h3C;
    bd0 = bd_cnt;
    send(1, 1);
    chk("t1 byte_done pulses", bd_cnt - bd0, 1);
    drain_rx();
    pulse_clr();

    // Table: all modes and bit orders, two-word frames both ways
    for (int r = 0; r < 12; r++) begin
      set_mode(vecs[r].cpol, vecs[r].cpha, vecs[r].lsb);
      tx_push(vecs[r].s0); exp_miso_q.push_back(vecs[r].s0);
      tx_push(vecs[r].s1); exp_miso_q.push_back(vecs[r].s1);
      mst_tx[0] = vecs[r].m0;
      mst_tx[1] = vecs[r].m1;
      send(2, 2);
      drain_rx();
      chk("t2 tx_count", {27'd0, tx_count}, 0);
      chk("t2 rx_count", {27'd0, rx_count}, 0);
      pulse_clr();
    end

    // Empty TX FIFO gives the default word and flags underrun
    set_mode(0, 0, 0);
    chk("t3 underrun clear", {31'd0, tx_underrun}, 0);
    mst_tx[0] = 8'h55; exp_miso_q.push_back(8'hFF);
    send(1, 1);
    chk("t3 underrun set", {31'd0, tx_underrun}, 1);
    drain_rx();
    pulse_clr();
    chk("t3 underrun cleared", {31'd0, tx_underrun}, 0);

    // 17 words into a 16-deep RX FIFO with no reads
    for (int k = 0; k < 17; k++) begin
      mst_tx[k] = 8'(k * 13 + 1);
      exp_miso_q.push_back(8'hFF);
    end
    bd0 = bd_cnt;
    send(17, 16);
    chk("t4 rx_count", {27'd0, rx_count}, 16);
    chk("t4 rx_overrun", {31'd0, rx_overrun}, 1);
    chk("t4 byte_done pulses", bd_cnt - bd0, 17);
    drain_rx();
    pulse_clr();
    chk("t4 overrun cleared", {31'd0, rx_overrun}, 0);

    // Frame aborted after 3 bits, then a complete word
    mst_tx[0] = 8'h0F;
    xfer(1, 3, 1'b1);
    chk("t5 rx_count after abort", {27'd0, rx_count}, 0);
    mst_tx[0] = 8'hC3; exp_miso_q.push_back(8'hFF);
    send(1, 1);
    chk("t5 rx_count", {27'd0, rx_count}, 1);
    drain_rx();
    pulse_clr();

    // Reset in the middle of a frame with queued TX words
    tx_push(8'h11); tx_push(8'h22);
    mst_tx[0] = 8'hF0;
    xfer(1, 4, 1'b0);
    chk("t6 miso_oe in frame", {31'd0, miso_oe}, 1);
    rst = 1'b1; cs = 1'b1; sclk = cpol;
    cyc(H);
    rst = 1'b0;
    cyc(1);
    chk("t6 tx_count", {27'd0, tx_count}, 0);
    chk("t6 rx_count", {27'd0, rx_count}, 0);
    chk("t6 miso_oe", {31'd0, miso_oe}, 0);
    chk("t6 rx_empty", {31'd0, rx_empty}, 1);
    cyc(H);
    chk("t6 no late push", {27'd0, rx_count}, 0);
    tx_push(8'h5A); exp_miso_q.push_back(8'h5A);
    mst_tx[0] = 8'h96;
    send(1, 1);
    drain_rx();
    pulse_clr();

    // TX FIFO full: 17th write dropped, 16-word frame in mode 3
    set_mode(1, 1, 0);
    for (int k = 0; k < 17; k++) begin
      tx_push(8'(k * 29 + 7));
      if (k < 16) exp_miso_q.push_back(8'(k * 29 + 7));
    end
    chk("t7 tx_count full", {27'd0, tx_count}, 16);
    chk("t7 tx_full", {31'd0, tx_full}, 1);
    for (int k = 0; k < 16; k++) mst_tx[k] = 8'(8'hF3 - k * 11);
    send(16, 16);
    chk("t7 tx_count drained", {27'd0, tx_count}, 0);
    chk("t7 no underrun", {31'd0, tx_underrun}, 0);
    drain_rx();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
